// File: rtl/byte_comp_seq_if.sv
// Start/done handshake between the byte-compare sequencer and the shared
// byte comparator.
interface byte_comp_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] cmp_byte_a;
    logic [DATA_WIDTH-1:0] cmp_byte_b;
    logic                  cmp_start;
    logic                  cmp_done;
    logic [DATA_WIDTH-1:0] cmp_result;

    modport master (
        output cmp_byte_a,
        output cmp_byte_b,
        output cmp_start,
        input  cmp_done,
        input  cmp_result
    );

    modport slave (
        input  cmp_byte_a,
        input  cmp_byte_b,
        input  cmp_start,
        output cmp_done,
        output cmp_result
    );
endinterface

// File: rtl/byte_comp_seq.sv
// Multi-byte magnitude compare, MS byte first, one byte per comparator
// transaction; stops at the first differing byte or on comparator timeout.
module byte_comp_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0]  op_a,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0]  op_b,
    output logic                             busy,
    output logic                             done,
    output logic                             a_gt_b,
    output logic                             a_lt_b,
    output logic                             a_eq_b,
    output logic                             err,
    byte_comp_seq_if.master                  cmp
);
    localparam int OPW = DATA_WIDTH * NUM_BYTES;
    localparam int IW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [OPW-1:0]        a_q, a_d;
    logic [OPW-1:0]        b_q, b_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0] byte_a_q, byte_a_d;
    logic [DATA_WIDTH-1:0] byte_b_q, byte_b_d;
    logic                  start_q, start_d;
    logic                  busy_d, done_d;
    logic                  gt_d, lt_d, eq_d, err_d;
    logic [IW-1:0]         idx_m1;
    logic [IW-1:0]         idx_top;
    logic [DATA_WIDTH-1:0] cur_a;
    logic                  k_bit;

    function automatic logic [DATA_WIDTH-1:0] pick(
        input logic [OPW-1:0] v,
        input logic [IW-1:0]  i
    );
        pick = '0;
        for (int n = 0; n < NUM_BYTES; n++) begin
            if (i == IW'(n)) pick = v[n*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    assign idx_m1  = idx_q - 1'b1;
    assign idx_top = IW'(NUM_BYTES - 1);
    assign cur_a   = pick(a_q, idx_q);

    // Sign of the difference comes from A at the highest differing bit.
    always_comb begin
        k_bit = 1'b0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (res_q[j]) k_bit = cur_a[j];
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        res_d    = res_q;
        byte_a_d = byte_a_q;
        byte_b_d = byte_b_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        gt_d     = a_gt_b;
        lt_d     = a_lt_b;
        eq_d     = a_eq_b;
        err_d    = err;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    idx_d    = idx_top;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b0;
                    err_d    = 1'b0;
                    byte_a_d = pick(op_a, idx_top);
                    byte_b_d = pick(op_b, idx_top);
                    start_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cmp.cmp_done) begin
                    res_d   = cmp.cmp_result;
                    state_d = S_EVAL;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (res_q != '0) begin
                    gt_d    = k_bit;
                    lt_d    = ~k_bit;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_m1;
                    byte_a_d = pick(a_q, idx_m1);
                    byte_b_d = pick(b_q, idx_m1);
                    start_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            res_q    <= '0;
            byte_a_q <= '0;
            byte_b_q <= '0;
            start_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_gt_b   <= 1'b0;
            a_lt_b   <= 1'b0;
            a_eq_b   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            res_q    <= res_d;
            byte_a_q <= byte_a_d;
            byte_b_q <= byte_b_d;
            start_q  <= start_d;
            busy     <= busy_d;
            done     <= done_d;
            a_gt_b   <= gt_d;
            a_lt_b   <= lt_d;
            a_eq_b   <= eq_d;
            err      <= err_d;
        end
    end

    assign cmp.cmp_byte_a = byte_a_q;
    assign cmp.cmp_byte_b = byte_b_q;
    assign cmp.cmp_start  = start_q;
endmodule

// File: tb/tb_byte_comp_seq.sv
// Directed bench for byte_comp_seq with a delay-programmable comparator
// model returning a^b.
module tb_byte_comp_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, a_gt_b, a_lt_b, a_eq_b, err;

    int checks = 0;
    int errors = 0;

    byte_comp_seq_if #(.DATA_WIDTH(8)) bif ();

    byte_comp_seq #(
        .DATA_WIDTH(8),
        .NUM_BYTES (4),
        .TIMEOUT   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .a_gt_b(a_gt_b),
        .a_lt_b(a_lt_b),
        .a_eq_b(a_eq_b),
        .err   (err),
        .cmp   (bif)
    );

    always #5 clk = ~clk;

    // Comparator model: dly=1 answers the cycle after cmp_start, dly<1 never.
    int   dly = 1;
    int   cnt = 0;
    logic pend = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            bif.cmp_done   <= 1'b0;
            bif.cmp_result <= '0;
            pend           <= 1'b0;
            cnt            <= 0;
        end else begin
            bif.cmp_done <= 1'b0;
            if (bif.cmp_start) begin
                if (dly == 1) begin
                    bif.cmp_done   <= 1'b1;
                    bif.cmp_result <= bif.cmp_byte_a ^ bif.cmp_byte_b;
                    pend           <= 1'b0;
                end else if (dly > 1) begin
                    pend <= 1'b1;
                    cnt  <= dly - 2;
                end else begin
                    pend <= 1'b0;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    bif.cmp_done   <= 1'b1;
                    bif.cmp_result <= bif.cmp_byte_a ^ bif.cmp_byte_b;
                    pend           <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; lat is the cycle (req edge = 0) in which done is seen.
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input int inj, output int lat,
                       output logic [3:0] fl, output int ns,
                       output logic [31:0] bytes);
        @(negedge clk);
        op_a = a;
        op_b = b;
        req  = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        lat   = 0;
        ns    = 0;
        bytes = '0;
        fl    = '0;
        for (int n = 1; n <= 200; n++) begin
            if (n == inj) begin
                req  = 1'b1;
                op_a = 32'hFF00_0000;
                op_b = 32'h0000_0000;
            end else if (n == inj + 1) begin
                req = 1'b0;
            end
            if (bif.cmp_start) begin
                ns++;
                bytes = {bytes[23:0], bif.cmp_byte_a};
            end
            if (done) begin
                lat = n;
                fl  = {a_gt_b, a_lt_b, a_eq_b, err};
                break;
            end
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    int          lat, ns;
    logic [3:0]  fl;
    logic [31:0] bytes;
    logic        seen;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs",
            {busy, done, a_gt_b, a_lt_b, a_eq_b, err, bif.cmp_start,
             bif.cmp_byte_a, bif.cmp_byte_b}, '0);
        reset = 1'b0;
        @(negedge clk);

        run(32'h1234_5678, 32'h1234_5678, -5, lat, fl, ns, bytes);
        chk("eq_latency", lat, 13);
        chk("eq_flags", fl, 4'b0010);
        chk("eq_starts", ns, 4);
        chk("eq_bytes", bytes, 32'h1234_5678);
        @(negedge clk);
        chk("eq_done_pulse", {done, busy}, 2'b00);
        chk("eq_flags_hold", {a_gt_b, a_lt_b, a_eq_b, err}, 4'b0010);

        run(32'h8000_0000, 32'h7FFF_FFFF, -5, lat, fl, ns, bytes);
        chk("msb_gt_latency", lat, 4);
        chk("msb_gt_flags", fl, 4'b1000);
        chk("msb_gt_starts", ns, 1);

        run(32'h7FFF_FFFF, 32'h8000_0000, -5, lat, fl, ns, bytes);
        chk("msb_lt_latency", lat, 4);
        chk("msb_lt_flags", fl, 4'b0100);

        run(32'h0000_00A5, 32'h0000_00A4, -5, lat, fl, ns, bytes);
        chk("lsb_gt_latency", lat, 13);
        chk("lsb_gt_flags", fl, 4'b1000);

        dly = 0;
        run(32'h1111_1111, 32'h2222_2222, -5, lat, fl, ns, bytes);
        chk("timeout_latency", lat, 19);
        chk("timeout_flags", fl, 4'b0001);
        repeat (3) @(negedge clk);
        chk("timeout_err_hold", {busy, err}, 2'b01);

        dly = 17;
        run(32'h8000_0000, 32'h0000_0000, -5, lat, fl, ns, bytes);
        chk("expiry_latency", lat, 20);
        chk("expiry_flags", fl, 4'b1000);
        dly = 1;

        @(negedge clk);
        op_a = 32'h1234_5678;
        op_b = 32'h1234_5678;
        req  = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_outs",
            {busy, done, a_gt_b, a_lt_b, a_eq_b, err, bif.cmp_start,
             bif.cmp_byte_a, bif.cmp_byte_b}, '0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("midreset_no_resume", seen, 1'b0);

        run(32'h0100_0000, 32'h0200_0000, -5, lat, fl, ns, bytes);
        chk("post_reset_latency", lat, 4);
        chk("post_reset_flags", fl, 4'b0100);

        run(32'h1234_5678, 32'h1234_5679, 3, lat, fl, ns, bytes);
        chk("busy_req_latency", lat, 13);
        chk("busy_req_flags", fl, 4'b0100);
        chk("busy_req_starts", ns, 4);
        chk("busy_req_bytes", bytes, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_comp_seq.md
# byte_comp_seq

Sequencer that compares two NUM_BYTES-wide operands by issuing one byte at a time to the shared byte comparator over its start/done handshake. It walks from the most-significant byte down and stops at the first byte that differs. It reports greater, less or equal, or an error if the comparator times out. It sits between the operand-producing logic and the single byte comparator instance.

## Interface

- DATA_WIDTH, 8, width of one comparator byte
- NUM_BYTES, 4, bytes per operand, ≥1
- TIMEOUT, 16, maximum WAIT cycles allowed for cmp_done, ≥1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  start a comparison; sampled only in IDLE
- op_a  in  DATA_WIDTH*NUM_BYTES  operand A; byte i = op_a[i*DATA_WIDTH +: DATA_WIDTH]
- op_b  in  DATA_WIDTH*NUM_BYTES  operand B, same layout
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a result is valid
- a_gt_b, a_lt_b, a_eq_b  out  1 each  result flags; at most one set
- err  out  1  comparator timeout; all flags 0 when set
- cmp_byte_a, cmp_byte_b  out  DATA_WIDTH  byte presented to the comparator
- cmp_start  out  1  one-cycle start pulse to the comparator
- cmp_done  in  1  comparator completion
- cmp_result  in  DATA_WIDTH  comparator per-bit output; bit j=1 means the bytes differ at bit j

## Operation

- The block is already decided to run on one clock. Reset is synchronous and active-high.
- States: IDLE, ISSUE, WAIT, EVAL, DONE. All outputs are registered.
- IDLE
  - If req=1: latch op_a/op_b, set idx=NUM_BYTES-1, clear all result flags and err, go to ISSUE.
  - req in any other state is ignored.
- ISSUE
  - Drive cmp_byte_a/cmp_byte_b with latched byte idx and assert cmp_start for this cycle only.
  - Clear the timer. Go to WAIT.
  - cmp_byte_a/cmp_byte_b hold their value until the next ISSUE.
- WAIT
  - cmp_start=0.
  - If cmp_done=1: register cmp_result and go to EVAL.
  - Otherwise increment the timer. When the timer reaches TIMEOUT, set err=1 and go to DONE.
  - If cmp_done and timer expiry coincide, cmp_done wins.
- EVAL
  - If registered cmp_result≠0: k = index of the highest set bit. Set a_gt_b = latched A byte idx bit k, and a_lt_b = its inverse. Go to DONE.
  - Else if idx=0: set a_eq_b=1 and go to DONE.
  - Else decrement idx and go to ISSUE.
- DONE
  - done=1 for this cycle, then go to IDLE.
- Result flags and err hold from DONE until the next accepted req, which clears them.
- cmp_done outside WAIT is ignored. cmp_result is used only as captured in WAIT.
- Reset at any point, including mid-compare:
  - State goes to IDLE next cycle.
  - busy, done, cmp_start, all flags and err = 0; cmp_byte_a/b = 0; idx and timer = 0.
  - No pending comparison resumes.

## Timing

- Cycle 0 is the edge where req is sampled in IDLE. ISSUE is cycle 1 and cmp_start is high in cycle 1.
- The comparator's minimum response is cmp_done high in the cycle after cmp_start. At that response, each byte costs 3 cycles (ISSUE, WAIT, EVAL).
- done latency = 3·n+1 cycles after req, where n is the number of bytes examined. For the default parameters:
  - MS-byte mismatch: done in cycle 4.
  - Equal operands: done in cycle 13.
- Each extra comparator wait cycle adds 1 cycle per byte.
- Timeout: done arrives TIMEOUT+2 cycles after the ISSUE of the stalled byte.
- busy rises the cycle after req is accepted and falls the cycle after done.
- Back-to-back: req held high while done pulses is accepted in the following IDLE cycle, at the earliest 1 cycle after done.

## Test plan

- Use default parameters and a comparator model that returns cmp_result = a^b one cycle after cmp_start.
- op_a=0x12345678, op_b=0x12345678 -> 4 cmp_start pulses on bytes 0x12, 0x34, 0x56, 0x78 in that order; done in cycle 13; a_eq_b=1, err=0.
- op_a=0x80000000, op_b=0x7FFFFFFF -> one cmp_start; done in cycle 4; a_gt_b=1. Swap the operands -> a_lt_b=1.
- op_a=0x000000A5, op_b=0x000000A4 -> done in cycle 13; a_gt_b=1 (k=0).
- Comparator never asserts cmp_done -> err=1, all flags 0, done in cycle 19. Assert cmp_done exactly on the expiry cycle -> normal result, err=0.
- Assert reset in cycle 5 of an equal compare -> busy=0, cmp_start=0, no done pulse. A new req for 0x01000000 vs 0x02000000 then completes with a_lt_b=1 in cycle 4.
- Assert req while busy -> ignored; operands are not re-latched; the result matches the first request.
